// File: rtl/mmio_io_responder.sv
// MMIO peripheral responder: output register with valid/ready handshake, input FIFO,
// LED register and synchronised switches, all reached through a 64-word register window.
// Optional feature: define IO_CYCLE_COUNTER_EN to add a loadable free-running cycle counter
// at byte address 0x18. Without it, 0x18 is unmapped.
module mmio_io_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned SW_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Word indices into the register window (io_addr[7:2]).
  localparam logic [5:0] RegOutData = 6'h00;
  localparam logic [5:0] RegOutStat = 6'h01;
  localparam logic [5:0] RegInData  = 6'h02;
  localparam logic [5:0] RegInStat  = 6'h03;
  localparam logic [5:0] RegLed     = 6'h04;
  localparam logic [5:0] RegSw      = 6'h05;
`ifdef IO_CYCLE_COUNTER_EN
  localparam logic [5:0] RegCycle   = 6'h06;
`endif

  logic [5:0] reg_idx;
  logic       unused_addr_lsbs;

  assign reg_idx          = io_addr[7:2];
  assign unused_addr_lsbs = ^io_addr[1:0];

  // State
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0]      cycle_q, cycle_d;
`endif

  // Decoded strobes and handshake events
  logic wr_out_data, wr_out_stat, wr_led;
  logic out_hs, out_load, out_drop;
  logic fifo_full, fifo_empty, push, pop;
  logic [7:0] count_byte;

  // Address decode and handshake qualification.
  always_comb begin
    wr_out_data = io_we && (reg_idx == RegOutData);
    wr_out_stat = io_we && (reg_idx == RegOutStat);
    wr_led      = io_we && (reg_idx == RegLed);
    out_hs      = out_valid_q && out_ready;
    // A write is accepted when the slot is free or is being drained on this very edge.
    out_load    = wr_out_data && (!out_valid_q || out_ready);
    out_drop    = wr_out_data && !out_load;
    fifo_full   = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty  = (count_q == '0);
    push        = in_valid && !fifo_full;
    pop         = io_rd && (reg_idx == RegInData) && !fifo_empty;
    count_byte  = 8'(count_q);
  end

  // Next state for the output channel and its overflow flag.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (out_load) begin
      out_data_d  = io_dout;
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
    // A fresh overflow wins over a clear on the same edge.
    if (out_drop) begin
      ovf_d = 1'b1;
    end else if (wr_out_stat) begin
      ovf_d = 1'b0;
    end
  end

  // Next state for FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Next state for the LED register and optional cycle counter.
  always_comb begin
    led_d = wr_led ? io_dout[LED_W-1:0] : led_q;
`ifdef IO_CYCLE_COUNTER_EN
    cycle_d = (io_we && (reg_idx == RegCycle)) ? io_dout : cycle_q + 32'd1;
`endif
  end

  // Control and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
`ifdef IO_CYCLE_COUNTER_EN
      cycle_q     <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      led_q       <= led_d;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
`ifdef IO_CYCLE_COUNTER_EN
      cycle_q     <= cycle_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_data;
    end
  end

  // Combinational read mux; unmapped words read zero.
  always_comb begin
    io_din = '0;
    case (reg_idx)
      RegOutData: io_din = out_data_q;
      RegOutStat: io_din = {30'b0, ovf_q, out_valid_q};
      RegInData:  io_din = fifo_empty ? 32'b0 : fifo_mem[rd_ptr_q];
      RegInStat:  io_din = {16'b0, count_byte, 6'b0, fifo_full, !fifo_empty};
      RegLed:     io_din = 32'(led_q);
      RegSw:      io_din = 32'(sw_sync_q);
`ifdef IO_CYCLE_COUNTER_EN
      RegCycle:   io_din = cycle_q;
`endif
      default:    io_din = '0;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = !fifo_full;
  assign led       = led_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: directed scenarios with literal expectations, then a
// randomised phase, with a queue-based reference model checked on every falling edge.
module tb_mmio_io_responder;

  localparam int D     = 8;
  localparam int LED_W = 16;
  localparam int SW_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       io_addr;
  logic [31:0]      io_dout;
  logic             io_we;
  logic             io_rd;
  logic [31:0]      io_din;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw;

  mmio_io_responder #(
    .FIFO_DEPTH(D),
    .LED_W     (LED_W),
    .SW_W      (SW_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_we    (io_we),
    .io_rd    (io_rd),
    .io_din   (io_din),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .led      (led),
    .sw       (sw)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0]      m_out_data;
  bit               m_out_valid;
  bit               m_ovf;
  logic [31:0]      m_fifo[$];
  logic [LED_W-1:0] m_led;
  logic [SW_W-1:0]  m_sw1, m_sw2;
  logic [31:0]      m_cnt;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int n;
    n = m_fifo.size();
    case (a[7:2])
      6'd0: return m_out_data;
      6'd1: return {30'b0, m_ovf, m_out_valid};
      6'd2: return (n > 0) ? m_fifo[0] : 32'h0;
      6'd3: return (n * 256) + ((n == D) ? 2 : 0) + ((n != 0) ? 1 : 0);
      6'd4: return 32'(m_led);
      6'd5: return 32'(m_sw2);
`ifdef IO_CYCLE_COUNTER_EN
      6'd6: return m_cnt;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out_data  = '0;
    m_out_valid = 1'b0;
    m_ovf       = 1'b0;
    m_fifo.delete();
    m_led       = '0;
    m_sw1       = '0;
    m_sw2       = '0;
    m_cnt       = '0;
  endtask

  // One clock edge of the register-map rules, evaluated from the pre-edge state.
  task automatic model_step();
    int  idx;
    bit  wr_od, push, pop, ovf_set;
    idx     = int'(io_addr[7:2]);
    wr_od   = io_we && idx == 0;
    push    = in_valid && m_fifo.size() < D;
    pop     = io_rd && idx == 2 && m_fifo.size() > 0;
    ovf_set = 1'b0;
    if (wr_od && (!m_out_valid || out_ready)) begin
      m_out_data  = io_dout;
      m_out_valid = 1'b1;
    end else begin
      if (wr_od) ovf_set = 1'b1;
      if (m_out_valid && out_ready) m_out_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (io_we && idx == 1) m_ovf = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(in_data);
    if (io_we && idx == 4) m_led = io_dout[LED_W-1:0];
    m_sw2 = m_sw1;
    m_sw1 = sw;
    if (io_we && idx == 6) m_cnt = io_dout;
    else m_cnt = m_cnt + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic expect_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    io_addr = a;
    #1;
    check32(nm, io_din, e);
  endtask

  // Compare process: every meaningful cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check32("io_din", io_din, exp_rd(io_addr));
      check32("out_data", out_data, m_out_data);
      check32("out_valid", 32'(out_valid), 32'(m_out_valid));
      check32("in_ready", 32'(in_ready), (m_fifo.size() < D) ? 32'd1 : 32'd0);
      check32("led", 32'(led), 32'(m_led));
    end
  end

  initial begin
    rst = 1'b1; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
    out_ready = 1'b0; in_data = '0; in_valid = 1'b0; sw = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values
    expect_rd(8'h04, 32'h0, "rst_out_stat");
    expect_rd(8'h0C, 32'h0, "rst_in_stat");
    expect_rd(8'h10, 32'h0, "rst_led");
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Output register, overflow, handshake, overflow clear
    io_addr = 8'h00; io_dout = 32'hDEADBEEF; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    check32("ow_valid", 32'(out_valid), 32'd1);
    check32("ow_data", out_data, 32'hDEADBEEF);
    io_addr = 8'h00; io_dout = 32'h1; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    expect_rd(8'h04, 32'h3, "ovf_stat");
    check32("ovf_data_kept", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check32("hs_valid", 32'(out_valid), 32'd0);
    io_addr = 8'h04; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    expect_rd(8'h04, 32'h0, "ovf_clear");

    // Fill FIFO, refuse 9th, drain in order
    io_addr = 8'h0C; in_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      in_data = 32'h10 + 32'(i);
      tick();
    end
    check32("full_in_ready", 32'(in_ready), 32'd0);
    expect_rd(8'h0C, 32'h0803, "full_stat");
    in_data = 32'h99;
    tick();
    in_valid = 1'b0;
    expect_rd(8'h0C, 32'h0803, "ninth_refused");
    for (int i = 0; i < D; i++) begin
      io_addr = 8'h08; io_rd = 1'b1;
      #1;
      check32("drain", io_din, 32'h10 + 32'(i));
      tick();
    end
    io_rd = 1'b0;
    expect_rd(8'h08, 32'h0, "empty_read");
    expect_rd(8'h0C, 32'h0, "empty_stat");

    // Count 3, then concurrent push/pop across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h20 + 32'(i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h23 + 32'(i);
      io_addr = 8'h08; io_rd = 1'b1;
      #1;
      check32("pushpop_head", io_din, 32'h20 + 32'(i));
      tick();
    end
    in_valid = 1'b0; io_rd = 1'b0;
    expect_rd(8'h0C, 32'h0301, "pushpop_count");
    for (int i = 0; i < 3; i++) begin
      io_addr = 8'h08; io_rd = 1'b1;
      #1;
      check32("wrap_order", io_din, 32'h25 + 32'(i));
      tick();
    end
    io_rd = 1'b0;

    // Empty + pop + push: pop ignored, push lands
    io_addr = 8'h08; io_rd = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    #1;
    check32("empty_pop_read", io_din, 32'h0);
    tick();
    io_rd = 1'b0; in_valid = 1'b0;
    expect_rd(8'h0C, 32'h0101, "empty_pop_push");
    io_rd = 1'b1; io_addr = 8'h08;
    tick();
    io_rd = 1'b0;

    // Switch synchroniser latency and LED write
    sw = 16'h00A5;
    expect_rd(8'h14, 32'h0, "sw_edge0");
    tick();
    expect_rd(8'h14, 32'h0, "sw_edge1");
    tick();
    expect_rd(8'h14, 32'hA5, "sw_edge2");
    io_addr = 8'h10; io_dout = 32'hFFFF1234; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    check32("led_port", 32'(led), 32'h1234);
    expect_rd(8'h10, 32'h1234, "led_read");

    // Cycle counter (or unmapped 0x18)
`ifdef IO_CYCLE_COUNTER_EN
    io_addr = 8'h18; io_dout = 32'hFFFFFFFE; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    tick();
    tick();
    tick();
    expect_rd(8'h18, 32'h1, "cycle_wrap");
`else
    io_addr = 8'h18; io_dout = 32'hFFFFFFFE; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    expect_rd(8'h18, 32'h0, "unmapped_18");
`endif
    expect_rd(8'h1C, 32'h0, "unmapped_1c");

    // Randomised traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      io_addr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      io_dout   = $urandom;
      io_we     = ($urandom_range(0, 9) < 3);
      io_rd     = ($urandom_range(0, 9) < 4);
      in_valid  = ($urandom_range(0, 9) < 5);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      tick();
    end

    io_we = 1'b0; io_rd = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
